// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU.
// Holds the 4-bit operation encoding {funct7[5], funct3}, the datapath widths
// and a small bit-reversal helper used by the barrel shifter.
// Optional feature macro used by the ALU: ALU_FLAGS_EN (adds the registered zero flag).
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int MODE_W = 4;
    localparam int SHAMT_W = 5;

    // Operation codes; any value not listed here is an undefined op and yields zero.
    typedef enum logic [MODE_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Mirror a word end for end so a left shift can reuse the right-shift stages.
    function automatic logic [XLEN-1:0] bitReverse(input logic [XLEN-1:0] value);
        logic [XLEN-1:0] reversed;
        reversed = '0;
        for (int i = 0; i < XLEN; i++) begin
            reversed[i] = value[XLEN-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter serving SLL, SRL and SRA.
// dir_i = 0 shifts left, dir_i = 1 shifts right; arith_i selects sign fill on
// right shifts. Left shifts are done by mirroring the word, shifting right with
// zero fill, and mirroring back, so only one set of stages is needed.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               dir_i,
    input  logic               arith_i,
    output logic [XLEN-1:0]    data_o
);

    logic            fillBit;
    logic [XLEN-1:0] stage0;
    logic [XLEN-1:0] stage1;
    logic [XLEN-1:0] stage2;
    logic [XLEN-1:0] stage3;
    logic [XLEN-1:0] stage4;
    logic [XLEN-1:0] stage5;

    // Right-shift ladder of 1/2/4/8/16 positions; sign fill only for arithmetic right shifts.
    always_comb begin
        fillBit = arith_i & dir_i & data_i[XLEN-1];
        stage0  = dir_i ? data_i : bitReverse(data_i);
        stage1  = shamt_i[0] ? {{1{fillBit}},  stage0[XLEN-1:1]}  : stage0;
        stage2  = shamt_i[1] ? {{2{fillBit}},  stage1[XLEN-1:2]}  : stage1;
        stage3  = shamt_i[2] ? {{4{fillBit}},  stage2[XLEN-1:4]}  : stage2;
        stage4  = shamt_i[3] ? {{8{fillBit}},  stage3[XLEN-1:8]}  : stage3;
        stage5  = shamt_i[4] ? {{16{fillBit}}, stage4[XLEN-1:16]} : stage4;
        data_o  = dir_i ? stage5 : bitReverse(stage5);
    end

endmodule

// File: rtl/alu.sv
// 32-bit RV32I ALU with a registered result (one cycle latency, new op every cycle).
// Add and subtract share one adder (rs2 inverted plus carry-in); SLT/SLTU reuse
// that subtractor's sign and borrow. Shifts go through alu_shifter.
// Undefined mode codes produce a zero result.
// Optional macro ALU_FLAGS_EN: adds the registered zero flag output (reset value 1).
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [MODE_W-1:0] mode,
    output logic [XLEN-1:0]   rd
`ifdef ALU_FLAGS_EN
    ,
    output logic              zero
`endif
);

    logic            subtractEn;
    logic [XLEN-1:0] operandB;
    logic [XLEN:0]   adderFull;
    logic [XLEN-1:0] adderSum;
    logic            ltUnsigned;
    logic            ltSigned;
    logic            shiftRight;
    logic            shiftArith;
    logic [XLEN-1:0] shiftResult;
    logic [XLEN-1:0] rd_d;
    logic [XLEN-1:0] rd_q;

    // Shared adder: SUB, SLT and SLTU all compute rs1 + ~rs2 + 1.
    always_comb begin
        subtractEn = (mode == ALU_SUB) || (mode == ALU_SLT) || (mode == ALU_SLTU);
        operandB   = subtractEn ? ~rs2 : rs2;
        adderFull  = {1'b0, rs1} + {1'b0, operandB} + {{XLEN{1'b0}}, subtractEn};
        adderSum   = adderFull[XLEN-1:0];
        ltUnsigned = ~adderFull[XLEN];
        ltSigned   = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : adderSum[XLEN-1];
    end

    // Shifter controls: right for SRL/SRA, sign fill only for SRA.
    always_comb begin
        shiftRight = (mode == ALU_SRL) || (mode == ALU_SRA);
        shiftArith = (mode == ALU_SRA);
    end

    alu_shifter u_shifter (
        .data_i  (rs1),
        .shamt_i (rs2[SHAMT_W-1:0]),
        .dir_i   (shiftRight),
        .arith_i (shiftArith),
        .data_o  (shiftResult)
    );

    // Result select; unlisted mode codes fall through to zero.
    always_comb begin
        rd_d = '0;
        case (mode)
            ALU_ADD:  rd_d = adderSum;
            ALU_SUB:  rd_d = adderSum;
            ALU_SLL:  rd_d = shiftResult;
            ALU_SRL:  rd_d = shiftResult;
            ALU_SRA:  rd_d = shiftResult;
            ALU_SLT:  rd_d = {{(XLEN-1){1'b0}}, ltSigned};
            ALU_SLTU: rd_d = {{(XLEN-1){1'b0}}, ltUnsigned};
            ALU_XOR:  rd_d = rs1 ^ rs2;
            ALU_OR:   rd_d = rs1 | rs2;
            ALU_AND:  rd_d = rs1 & rs2;
            default:  rd_d = '0;
        endcase
    end

    // Output register; synchronous reset overrides any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

`ifdef ALU_FLAGS_EN
    logic zero_d;
    logic zero_q;

    // Zero flag is computed from the next result so it lines up with rd.
    always_comb begin
        zero_d = (rd_d == '0);
    end

    // Flag register; reset value reflects the cleared result.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences and
// randomized back-to-back operations checked against a reference model.
// Build with ALU_FLAGS_EN defined to also check the zero flag.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  mode;
    logic [31:0] rd;
`ifdef ALU_FLAGS_EN
    logic        zero;
`endif

    int checks;
    int errors;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .rs1   (rs1),
        .rs2   (rs2),
        .mode  (mode),
        .rd    (rd)
`ifdef ALU_FLAGS_EN
        ,
        .zero  (zero)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expect_rd;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference model written straight from the instruction semantics.
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return 32'($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one set of inputs on the falling edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset = rst;
        mode  = op;
        rs1   = a;
        rs2   = b;
    endtask

    // Wait for the capturing edge, then compare just after it.
    task automatic checkOutput(input string name, input logic [31:0] expRd);
        @(posedge clk);
        #1;
        checks++;
        if (rd !== expRd) begin
            errors++;
            $display("[TB] FAIL %s: rd got 0x%08h expected 0x%08h", name, rd, expRd);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (zero !== (expRd == 32'd0)) begin
            errors++;
            $display("[TB] FAIL %s zero: got %0b expected %0b", name, zero, (expRd == 32'd0));
        end
`endif
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;

        checks = 0;
        errors = 0;

        // Directed table built from the instruction rules and boundary cases.
        vecs.push_back('{ALU_ADD,  32'd18,         32'd12,         32'd30,         "add_18_12"});
        vecs.push_back('{ALU_SUB,  32'd18,         32'd12,         32'd6,          "sub_18_12"});
        vecs.push_back('{ALU_ADD,  32'hFFFFFFFF,   32'd1,          32'd0,          "add_wrap"});
        vecs.push_back('{ALU_SUB,  32'd0,          32'd1,          32'hFFFFFFFF,   "sub_wrap"});
        vecs.push_back('{ALU_SLL,  32'd18,         32'd1,          32'd36,         "sll_18_1"});
        vecs.push_back('{ALU_SRL,  32'hFFFFFFFC,   32'd1,          32'h7FFFFFFE,   "srl_neg"});
        vecs.push_back('{ALU_SRA,  32'hFFFFFFFC,   32'd1,          32'hFFFFFFFE,   "sra_neg"});
        vecs.push_back('{ALU_SLL,  32'h80000001,   32'd33,         32'h00000002,   "sll_by_33"});
        vecs.push_back('{ALU_SRA,  32'h80000000,   32'd0,          32'h80000000,   "sra_by_0"});
        vecs.push_back('{ALU_SLL,  32'd5,          32'hFFFFFFE0,   32'd5,          "sll_upper_ignored"});
        vecs.push_back('{ALU_SRA,  32'h80000000,   32'd31,         32'hFFFFFFFF,   "sra_by_31"});
        vecs.push_back('{ALU_SRL,  32'h80000000,   32'd31,         32'h00000001,   "srl_by_31"});
        vecs.push_back('{ALU_SLT,  32'hFFFFFFFF,   32'd1,          32'd1,          "slt_neg1_1"});
        vecs.push_back('{ALU_SLTU, 32'hFFFFFFFF,   32'd1,          32'd0,          "sltu_max_1"});
        vecs.push_back('{ALU_SLT,  32'h80000000,   32'h7FFFFFFF,   32'd1,          "slt_min_max"});
        vecs.push_back('{ALU_SLTU, 32'h80000000,   32'h7FFFFFFF,   32'd0,          "sltu_min_max"});
        vecs.push_back('{ALU_SLT,  32'd7,          32'd7,          32'd0,          "slt_equal"});
        vecs.push_back('{ALU_XOR,  32'd24,         32'd20,         32'd12,         "xor_24_20"});
        vecs.push_back('{ALU_OR,   32'd24,         32'd20,         32'd28,         "or_24_20"});
        vecs.push_back('{ALU_AND,  32'd24,         32'd20,         32'd16,         "and_24_20"});
        vecs.push_back('{4'b1111,  32'd24,         32'd20,         32'd0,          "undef_1111"});
        vecs.push_back('{4'b1001,  32'hFFFFFFFF,   32'd1,          32'd0,          "undef_1001"});

        // Inputs left undriven before the first reset edge.
        reset = 1'b1;
        applyStimulus(1'b1, ALU_ADD, 32'd18, 32'd12);
        checkOutput("reset_first", 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, ALU_OR, 32'hFFFFFFFF, 32'h1234);
            checkOutput("reset_held", 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput(vecs[i].name, vecs[i].expect_rd);
        end

        // Result must be nonzero, then reset mid-stream clears it, then ops resume.
        applyStimulus(1'b0, ALU_ADD, 32'd100, 32'd1);
        checkOutput("pre_reset_op", 32'd101);
        applyStimulus(1'b1, ALU_ADD, 32'd100, 32'd1);
        checkOutput("reset_midstream", 32'd0);
        applyStimulus(1'b0, ALU_SUB, 32'd100, 32'd1);
        checkOutput("post_reset_op", 32'd99);

        // Randomized back-to-back ops, one new op every cycle, mixed with edge operands.
        pool[0] = 32'h00000000; pool[1] = 32'hFFFFFFFF; pool[2] = 32'h80000000; pool[3] = 32'h7FFFFFFF;
        pool[4] = 32'h00000001; pool[5] = 32'h0000001F; pool[6] = 32'h00000020; pool[7] = 32'hAAAA5555;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1'b1, op, a, b);
                checkOutput("rand_reset", 32'd0);
            end else begin
                applyStimulus(1'b0, op, a, b);
                checkOutput("rand_op", refAlu(op, a, b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
